sm83_bus_unit: RTL
==================

Name: sm83_bus_unit

Overview:
Parametrised memory bus sequencer that replaces the core's direct combinational r_addr/w_addr/w_wen drive. It divides time into M-cycles of T_PER_M T-cycles and arbitrates between N_REQ requesters, for example the core and OAM DMA. Each M-cycle carries at most one memory transaction and can be stretched by memory wait states. It emits m_tick so the control FSM advances exactly once per completed M-cycle.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
N_REQ, 2, number of requesters (index 0 = highest fixed priority)
T_PER_M, 4, T-cycles per M-cycle, legal range 2..8
MAX_WAIT, 15, maximum wait cycles before timeout, legal range >=1
ROUND_ROBIN, 0, 0 = fixed priority, 1 = round-robin arbitration

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  N_REQ  per-requester transaction request
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  packed write data
req_grant  out  N_REQ  one-hot; request accepted this cycle
rsp_valid  out  N_REQ  one-cycle completion pulse for requester i
rsp_err  out  1  qualifies rsp_valid; 1 = timed out
rsp_rdata  out  DATA_W  read data, valid with rsp_valid
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_ren  out  1  read strobe
mem_wen  out  1  write strobe
mem_rdata  in  DATA_W  bus read data
mem_ready  in  1  memory completes the access this cycle
m_tick  out  1  last cycle of the current M-cycle
busy  out  1  transaction in flight

Behaviour:
- Reset values: all outputs 0. tcnt=0, wait counter 0, rr pointer 0, state IDLE.
- States:
  - IDLE: no transaction in the current M-cycle.
  - ACCESS: transaction latched, tcnt < T_PER_M-1.
  - STROBE: tcnt = T_PER_M-1, strobe asserted, waiting for mem_ready.
- tcnt: counts 0..T_PER_M-1 and wraps. It increments every cycle except in STROBE while mem_ready=0.
- Arbitration:
  - Occurs only in the cycle tcnt=0.
  - req_grant is combinational. It is high in that cycle for the winner only.
  - Winner's we/addr/wdata are latched at that edge. busy=1 from the next cycle.
  - Requesters hold valid/we/addr/wdata stable until granted and may change them after the grant cycle.
  - Fixed priority: lowest asserted index wins.
  - Round-robin: search starts at (last_granted+1) mod N_REQ; the pointer updates only on a grant.
- Address phase: mem_addr and mem_wdata are registered from the latch. They are stable from tcnt=1 through completion. In IDLE M-cycles they hold their last values.
- Strobe: mem_ren (read) or mem_wen (write) is high only in STROBE, and never both.
- Completion, on the first STROBE cycle with mem_ready=1:
  - m_tick=1.
  - rsp_valid[i]=1 on the next cycle, with rsp_err=0.
  - For reads, rsp_rdata = mem_rdata sampled at the completing edge.
  - tcnt wraps to 0 and the state leaves STROBE.
- Wait states:
  - Each STROBE cycle with mem_ready=0 increments the wait counter.
  - When the counter reaches MAX_WAIT with ready still low, the access completes as a timeout: strobe drops, m_tick=1, rsp_valid[i]=1 and rsp_err=1 next cycle, rsp_rdata = all ones (open bus 0xFF).
  - The wait counter clears on every completion.
- IDLE M-cycle: no strobe. m_tick=1 when tcnt=T_PER_M-1.
- Back-to-back: a new grant can occur at the tcnt=0 cycle directly following a completion, in the same cycle as the previous rsp_valid. Sustained throughput is one transaction per T_PER_M cycles with zero waits.
- mem_ready is ignored outside STROBE.
- Simultaneous requests: exactly one grant. Losers keep req_valid and compete again at the next M-cycle boundary.
- Reset mid-transaction: strobes drop immediately (asynchronous). No rsp_valid is ever issued for the aborted access. The first cycle after release is tcnt=0.
- rsp_valid, req_grant and m_tick are single-cycle pulses. rsp_rdata holds its value until the next completion.

Test Plan:
- T_PER_M=4; requester 1 reads 0xC000, mem_ready=1, mem_rdata=0x5A → grant at tcnt0; mem_ren high for only 1 cycle at tcnt3; m_tick at tcnt3; rsp_valid[1] and rsp_rdata=0x5A on the next cycle.
- Requester 0 writes 0x42 to 0xFF46 with mem_ready held low for 3 STROBE cycles → mem_wen high for 4 cycles, m_tick delayed 3 cycles, rsp_err=0, tcnt frozen during the waits.
- MAX_WAIT=15, mem_ready stuck at 0 on a read → strobe drops after 15 wait cycles; rsp_valid with rsp_err=1 and rsp_rdata=0xFF.
- Both requesters continuously valid: with ROUND_ROBIN=0 → every grant goes to 0. With ROUND_ROBIN=1 → grants alternate 0,1,0,1 on consecutive M-cycles, each transaction taking 4 cycles.
- rst asserted during a STROBE wait → mem_ren and mem_wen drop the same cycle; no rsp_valid pulse appears; after release, an idle M-cycle gives m_tick 4 cycles later.
- No requests for 3 M-cycles → m_tick every 4th cycle, no strobes, mem_addr unchanged, busy=0.

Source files
------------

// File: rtl/sm83_bus_unit.sv
// M-cycle memory bus sequencer: arbitrates N_REQ requesters at each M-cycle
// boundary, runs one strobed access per M-cycle, stretches on wait states.
module sm83_bus_unit #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int N_REQ       = 2,
  parameter int T_PER_M     = 4,
  parameter int MAX_WAIT    = 15,
  parameter int ROUND_ROBIN = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_grant,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_ren,
  output logic                      mem_wen,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ready,
  output logic                      m_tick,
  output logic                      busy
);

  localparam int TW = $clog2(T_PER_M);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [TW-1:0] T_LAST    = TW'(T_PER_M - 1);
  localparam logic [TW-1:0] T_PRE     = TW'(T_PER_M - 2);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, STROBE} state_t;

  state_t          state;
  logic [TW-1:0]   tcnt;
  logic [WW-1:0]   wait_cnt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic            owner_we;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            arb_en;
  logic            done_ok;
  logic            done_to;

  // Candidates are scanned from farthest to nearest so the nearest one wins.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (ROUND_ROBIN != 0) begin
        j = int'(rr_ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
      end else begin
        j = k;
      end
      if (req_valid[IW'(j)]) begin
        win_found = 1'b1;
        win_idx   = IW'(j);
      end
    end
  end

  // tcnt is only ever 0 in IDLE, so the boundary cycle is the arbitration slot.
  assign arb_en = (tcnt == '0) && !rst;

  always_comb begin
    req_grant = '0;
    if (arb_en && win_found) req_grant[win_idx] = 1'b1;
  end

  assign done_ok = (state == STROBE) && mem_ready;
  assign done_to = (state == STROBE) && !mem_ready && (wait_cnt == WAIT_LAST);
  assign m_tick  = done_ok || done_to || ((state == IDLE) && (tcnt == T_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      wait_cnt  <= '0;
      rr_ptr    <= '0;
      owner     <= '0;
      owner_we  <= 1'b0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (arb_en && win_found) begin
            owner     <= win_idx;
            owner_we  <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            busy      <= 1'b1;
            tcnt      <= tcnt + 1'b1;
            if (ROUND_ROBIN != 0)
              rr_ptr <= (win_idx == IDX_LAST) ? '0 : win_idx + 1'b1;
            // With two T-cycles per M-cycle the strobe starts right after the grant.
            if (T_PER_M == 2) begin
              state   <= STROBE;
              mem_ren <= !req_we[win_idx];
              mem_wen <= req_we[win_idx];
            end else begin
              state <= ACCESS;
            end
          end else begin
            tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
          end
        end
        ACCESS: begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == T_PRE) begin
            state   <= STROBE;
            mem_ren <= !owner_we;
            mem_wen <= owner_we;
          end
        end
        STROBE: begin
          if (done_ok || done_to) begin
            state            <= IDLE;
            tcnt             <= '0;
            wait_cnt         <= '0;
            mem_ren          <= 1'b0;
            mem_wen          <= 1'b0;
            busy             <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            rsp_err          <= done_to;
            // A timed-out access returns open-bus data.
            if (done_to)        rsp_rdata <= '1;
            else if (!owner_we) rsp_rdata <= mem_rdata;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
